// File: rtl/sub_xfer_ctrl_if.sv
// sub_xfer_ctrl_if
// Bundles the sequencer's start/status, M1 read port, subtractor operand/result
// and M2 write port signals.
//   master : the sequencer (sub_xfer_ctrl)
//   slave  : memories, subtractor and the requester of transfers
// Signals:
//   start            transfer request
//   m1_rd/m1_addr    M1 read strobe/address, m1_dout read data (next cycle)
//   DOut2/DOut1      registered minuend/subtrahend, SUBOut = DOut2-DOut1
//   m2_wr/m2_addr    M2 write strobe/address, m2_din write data
//   busy/done        status, neg_cnt count of wrapped-negative results
interface sub_xfer_if #(
  parameter int AW = 8
) ();
  logic          start;
  logic          m1_rd;
  logic [AW-1:0] m1_addr;
  logic [7:0]    m1_dout;
  logic [7:0]    DOut2;
  logic [7:0]    DOut1;
  logic [7:0]    SUBOut;
  logic          m2_wr;
  logic [AW-1:0] m2_addr;
  logic [7:0]    m2_din;
  logic          busy;
  logic          done;
  logic [AW-1:0] neg_cnt;

  modport master (
    input  start, m1_dout, SUBOut,
    output m1_rd, m1_addr, DOut2, DOut1, m2_wr, m2_addr, m2_din,
           busy, done, neg_cnt
  );

  modport slave (
    output start, m1_dout, SUBOut,
    input  m1_rd, m1_addr, DOut2, DOut1, m2_wr, m2_addr, m2_din,
           busy, done, neg_cnt
  );
endinterface

// File: rtl/sub_xfer_ctrl.sv
// sub_xfer_ctrl
// Sequencer around the 8-bit subtractor on the M1 -> M2 transfer path.
// For each of NPAIRS pairs it reads M1[2i] (minuend) and M1[2i+1]
// (subtrahend), presents them as registered DOut2/DOut1, writes the
// subtractor result SUBOut into M2[i] and counts pairs with DOut1 > DOut2.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (aborts any transfer)
//   bus  sub_xfer_if master modport (see interface header)
module sub_xfer_ctrl #(
  parameter int AW     = 8,
  parameter int NPAIRS = 4
) (
  input  logic       clk,
  input  logic       rst,
  sub_xfer_if.master bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD_A  = 3'd1;
  localparam logic [2:0] RD_B  = 3'd2;
  localparam logic [2:0] LATCH = 3'd3;
  localparam logic [2:0] WR    = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic [AW-1:0] LAST_IDX = AW'(NPAIRS - 1);

  logic [2:0]    state;
  logic [AW-1:0] idx;
  logic [7:0]    dout1;
  logic [7:0]    dout2;
  logic [AW-1:0] neg_cnt;

  logic          m1_rd;
  logic [AW-1:0] m1_addr;
  logic          m2_wr;
  logic [AW-1:0] m2_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      dout1   <= '0;
      dout2   <= '0;
      neg_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            neg_cnt <= '0;
            idx     <= '0;
            state   <= RD_A;
          end
        end
        RD_A:  state <= RD_B;
        RD_B: begin
          // M1 data for the RD_A address (2i) is valid this cycle
          dout2 <= bus.m1_dout;
          state <= LATCH;
        end
        LATCH: begin
          dout1 <= bus.m1_dout;
          state <= WR;
        end
        WR: begin
          if ((dout1 > dout2) && (neg_cnt != '1))
            neg_cnt <= neg_cnt + AW'(1);
          if (idx == LAST_IDX) begin
            state <= DONE;
          end else begin
            idx   <= idx + AW'(1);
            state <= RD_A;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes and addresses are decoded only from registered state/idx, so they
  // are glitch-free at the edge and fall to zero immediately on reset.
  always_comb begin
    m1_rd   = 1'b0;
    m1_addr = '0;
    m2_wr   = 1'b0;
    m2_addr = '0;
    case (state)
      RD_A: begin
        m1_rd   = 1'b1;
        m1_addr = {idx[AW-2:0], 1'b0};
      end
      RD_B: begin
        m1_rd   = 1'b1;
        m1_addr = {idx[AW-2:0], 1'b1};
      end
      WR: begin
        m2_wr   = 1'b1;
        m2_addr = idx;
      end
      default: ;
    endcase
  end

  assign bus.m1_rd   = m1_rd;
  assign bus.m1_addr = m1_addr;
  assign bus.DOut2   = dout2;
  assign bus.DOut1   = dout1;
  assign bus.m2_wr   = m2_wr;
  assign bus.m2_addr = m2_addr;
  assign bus.m2_din  = bus.SUBOut;
  assign bus.busy    = (state != IDLE) && (state != DONE);
  assign bus.done    = (state == DONE);
  assign bus.neg_cnt = neg_cnt;

endmodule

// File: tb/tb_sub_xfer_ctrl.sv
// tb_sub_xfer_ctrl
// Directed bench for sub_xfer_ctrl: an NPAIRS=4 instance and an NPAIRS=1
// instance, each with its own synchronous-read M1, M2 and subtractor models.
module tb_sub_xfer_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr0 = 1'b0;

  always #5 clk = ~clk;

  sub_xfer_if #(.AW(8)) xif0 ();
  sub_xfer_if #(.AW(8)) xif1 ();

  sub_xfer_ctrl #(.AW(8), .NPAIRS(4)) dut0 (.clk(clk), .rst(rst), .bus(xif0));
  sub_xfer_ctrl #(.AW(8), .NPAIRS(1)) dut1 (.clk(clk), .rst(rst), .bus(xif1));

  logic [7:0] m1a [0:255];
  logic [7:0] m2a [0:255];
  logic [7:0] m1b [0:255];
  logic [7:0] m2b [0:255];
  int wr0 = 0;
  int wr1 = 0;

  assign xif0.SUBOut = xif0.DOut2 - xif0.DOut1;
  assign xif1.SUBOut = xif1.DOut2 - xif1.DOut1;

  always @(posedge clk) begin
    if (xif0.m1_rd) xif0.m1_dout <= m1a[xif0.m1_addr];
    if (clr0) begin
      for (int i = 0; i < 256; i++) m2a[i] <= 8'hAA;
    end else if (xif0.m2_wr) begin
      m2a[xif0.m2_addr] <= xif0.m2_din;
      wr0 <= wr0 + 1;
    end
  end

  always @(posedge clk) begin
    if (xif1.m1_rd) xif1.m1_dout <= m1b[xif1.m1_addr];
    if (xif1.m2_wr) begin
      m2b[xif1.m2_addr] <= xif1.m2_din;
      wr1 <= wr1 + 1;
    end
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_m2;
    @(negedge clk) clr0 = 1'b1;
    @(negedge clk) clr0 = 1'b0;
  endtask

  // Pulse start on dut0, then watch ncyc cycles (k=1 is the first cycle after
  // the sampling edge). Optionally re-pulse start at cycle restart_k and check
  // the pair-0 cycle sequence.
  task automatic run0(input int ncyc, input int restart_k, input bit pcheck,
                      output int done_k, output int done_n, output int busy_n);
    done_k = -1; done_n = 0; busy_n = 0;
    @(negedge clk) xif0.start = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      xif0.start = (k == restart_k);
      if (xif0.busy) busy_n++;
      if (xif0.done) begin
        done_n++;
        if (done_k < 0) done_k = k;
      end
      if (pcheck) begin
        case (k)
          1: begin
            chk("p0_rda_rd", xif0.m1_rd, 1);
            chk("p0_rda_addr", xif0.m1_addr, 0);
            chk("p0_rda_wr", xif0.m2_wr, 0);
          end
          2: begin
            chk("p0_rdb_rd", xif0.m1_rd, 1);
            chk("p0_rdb_addr", xif0.m1_addr, 1);
          end
          3: begin
            chk("p0_lat_rd", xif0.m1_rd, 0);
            chk("p0_lat_dout2", xif0.DOut2, 7);
          end
          4: begin
            chk("p0_wr_dout1", xif0.DOut1, 7);
            chk("p0_wr_strobe", xif0.m2_wr, 1);
            chk("p0_wr_addr", xif0.m2_addr, 0);
            chk("p0_wr_data", xif0.m2_din, 0);
          end
          5: chk("p0_wr_once", xif0.m2_wr, 0);
          default: ;
        endcase
      end
    end
  endtask

  int dk, dn, bn, w, dk2;

  initial begin
    xif0.start = 1'b0;
    xif1.start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      m1a[i] = 8'h00;
      m1b[i] = 8'h00;
    end
    m1a[0] = 8'd7; m1a[1] = 8'd7; m1a[2] = 8'd3;  m1a[3] = 8'd1;
    m1a[4] = 8'd9; m1a[5] = 8'd10; m1a[6] = 8'd10; m1a[7] = 8'd10;
    m1b[0] = 8'd0; m1b[1] = 8'd255;

    repeat (2) @(negedge clk);
    chk("rst_busy", xif0.busy, 0);
    chk("rst_done", xif0.done, 0);
    chk("rst_m1rd", xif0.m1_rd, 0);
    chk("rst_m2wr", xif0.m2_wr, 0);
    chk("rst_neg", xif0.neg_cnt, 0);
    chk("rst_dout", {xif0.DOut2, xif0.DOut1}, 0);
    clear_m2();
    rst = 1'b0;

    // basic four-pair transfer with pair-0 cycle checks
    w = wr0;
    run0(20, 0, 1'b1, dk, dn, bn);
    chk("t1_done_k", dk, 17);
    chk("t1_done_n", dn, 1);
    chk("t1_busy_n", bn, 16);
    chk("t1_writes", wr0 - w, 4);
    chk("t1_m2_0", m2a[0], 8'h00);
    chk("t1_m2_1", m2a[1], 8'h02);
    chk("t1_m2_2", m2a[2], 8'hFF);
    chk("t1_m2_3", m2a[3], 8'h00);
    chk("t1_neg", xif0.neg_cnt, 1);
    chk("t1_hold_d2", xif0.DOut2, 10);
    chk("t1_hold_d1", xif0.DOut1, 10);

    // start re-pulsed mid-transfer is ignored
    clear_m2();
    w = wr0;
    run0(22, 6, 1'b0, dk, dn, bn);
    chk("t2_done_k", dk, 17);
    chk("t2_done_n", dn, 1);
    chk("t2_writes", wr0 - w, 4);
    chk("t2_neg", xif0.neg_cnt, 1);

    // reset during pair 2 RD_B
    clear_m2();
    w = wr0;
    @(negedge clk) xif0.start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      xif0.start = 1'b0;
    end
    chk("t3_pre_rd", xif0.m1_rd, 1);
    chk("t3_pre_addr", xif0.m1_addr, 5);
    rst = 1'b1;
    #1;
    chk("t3_busy", xif0.busy, 0);
    chk("t3_done", xif0.done, 0);
    chk("t3_m1rd", xif0.m1_rd, 0);
    chk("t3_m1addr", xif0.m1_addr, 0);
    chk("t3_m2wr", xif0.m2_wr, 0);
    chk("t3_m2addr", xif0.m2_addr, 0);
    chk("t3_dout2", xif0.DOut2, 0);
    chk("t3_dout1", xif0.DOut1, 0);
    chk("t3_m2din", xif0.m2_din, 0);
    chk("t3_neg", xif0.neg_cnt, 0);
    @(negedge clk) rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("t3_writes", wr0 - w, 2);
    chk("t3_m2_1", m2a[1], 8'h02);
    chk("t3_m2_2", m2a[2], 8'hAA);
    chk("t3_m2_3", m2a[3], 8'hAA);
    w = wr0;
    run0(20, 0, 1'b0, dk, dn, bn);
    chk("t3_re_done_k", dk, 17);
    chk("t3_re_writes", wr0 - w, 4);
    chk("t3_re_m2_2", m2a[2], 8'hFF);
    chk("t3_re_m2_3", m2a[3], 8'h00);

    // start held high: back-to-back transfers, one IDLE cycle apart
    dn = 0; dk = -1; dk2 = -1;
    @(negedge clk) xif0.start = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (k == 36) xif0.start = 1'b0;
      if (xif0.done) begin
        dn++;
        if (dk < 0) dk = k; else dk2 = k;
      end
      if (k == 18) begin
        chk("t4_idle_busy", xif0.busy, 0);
        chk("t4_idle_neg", xif0.neg_cnt, 1);
      end
      if (k == 19) begin
        chk("t4_restart_busy", xif0.busy, 1);
        chk("t4_restart_neg", xif0.neg_cnt, 0);
        chk("t4_restart_addr", xif0.m1_addr, 0);
      end
    end
    chk("t4_done_n", dn, 2);
    chk("t4_done_k1", dk, 17);
    chk("t4_done_k2", dk2, 35);
    repeat (3) @(negedge clk);
    chk("t4_stopped", xif0.busy, 0);

    // single-pair instance: 0 - 255 wraps to 1
    w = wr1; dk = -1; bn = 0;
    @(negedge clk) xif1.start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      xif1.start = 1'b0;
      if (xif1.busy) bn++;
      if (xif1.done && dk < 0) dk = k;
    end
    chk("t5_done_k", dk, 5);
    chk("t5_busy_n", bn, 4);
    chk("t5_writes", wr1 - w, 1);
    chk("t5_m2_0", m2b[0], 8'h01);
    chk("t5_neg", xif1.neg_cnt, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/sub_xfer_ctrl.md
Name: sub_xfer_ctrl

Overview:
- Sequencer that sits around the 8-bit subtractor in the memory-to-memory transfer path.
- Fetches operand pairs from source memory M1 and drives them as registered DOut2 (minuend) and DOut1 (subtrahend) into the subtractor.
- Writes the subtractor's SUBOut into destination memory M2.
- Counts results that wrapped negative and signals completion.

Parameters:
- AW, 8, address width of M1 and M2.
- NPAIRS, 4, number of operand pairs per transfer; legal range 1..2^(AW-1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  begin transfer; sampled only in IDLE.
- m1_rd  output  1  M1 read strobe.
- m1_addr  output  AW  M1 read address.
- m1_dout  input  8  M1 read data; synchronous read, valid the cycle after m1_rd.
- DOut2  output  8  registered minuend to subtractor.
- DOut1  output  8  registered subtrahend to subtractor.
- SUBOut  input  8  subtractor result, combinational DOut2-DOut1 mod 256.
- m2_wr  output  1  M2 write strobe.
- m2_addr  output  AW  M2 write address.
- m2_din  output  8  M2 write data.
- busy  output  1  high in any state except IDLE and DONE.
- done  output  1  one-cycle pulse at end of transfer.
- neg_cnt  output  AW  number of pairs in the last transfer with DOut1 > DOut2.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE and idx goes to 0.
  - DOut1, DOut2, neg_cnt, m1_addr and m2_addr go to 0.
  - m1_rd, m2_wr, busy and done go to 0.
  - A reset mid-transfer aborts it. No further M2 writes occur, and a partially written M2 is left as is.
- Memory map: pair i sits at M1 addr 2i (minuend) and 2i+1 (subtrahend). Its result goes to M2 addr i.
- States and transitions:
  - IDLE: all strobes low. On start=1, clear neg_cnt and idx, then go to RD_A.
  - RD_A: m1_rd=1, m1_addr=2*idx. Next state RD_B.
  - RD_B: m1_rd=1, m1_addr=2*idx+1. At the clock edge DOut2 <= m1_dout (the addr 2i data). Next state LATCH.
  - LATCH: m1_rd=0. At the clock edge DOut1 <= m1_dout (the addr 2i+1 data). Next state WR.
  - WR:
    - Drives m2_wr=1, m2_addr=idx, m2_din=SUBOut. DOut1 and DOut2 are stable through WR, so SUBOut is settled.
    - If DOut1 > DOut2 (unsigned), neg_cnt increments at the edge.
    - If idx == NPAIRS-1, go to DONE; otherwise idx <= idx+1 and go to RD_A.
  - DONE: done=1 for exactly one cycle, busy=0. Next state IDLE.
- Latency: 4 cycles per pair. done is asserted 4*NPAIRS+1 cycles after the edge that sampled start.
- Outputs between transfers:
  - DOut1, DOut2 and neg_cnt hold their values through DONE and IDLE until the next start.
  - neg_cnt saturates at 2^AW-1. This is unreachable with legal NPAIRS.
- start handling:
  - start while busy or in DONE is ignored; there is no queuing.
  - start held high continuously restarts the transfer on the first IDLE cycle after DONE.
- m2_din is SUBOut passed through combinationally. The address outputs are registered or decoded from state/idx and must be glitch-free at the clock edge.
- Arithmetic:
  - All operands are unsigned 8-bit and results wrap mod 256 (e.g. 9-10 -> 8'hFF).
  - The block does no arithmetic on data itself, only the unsigned compare for neg_cnt.

Test Plan:
- M1 = {7,7,3,1,9,10,10,10}, NPAIRS=4, pulse start -> M2[0..3] = {8'h00, 8'h02, 8'hFF, 8'h00}; neg_cnt=1; done pulses once, 17 cycles after start sampled; busy high for 16 cycles.
- Cycle check on pair 0 -> m1_rd high for two cycles (addr 0 then 1); DOut2=7 after RD_B; DOut1=7 after LATCH; m2_wr high exactly one cycle with addr 0 and data 0.
- Assert rst during pair 2 RD_B -> all outputs 0 in the same cycle; M2[2] and M2[3] never written; a fresh start then completes normally.
- start pulsed again mid-transfer -> ignored; exactly 4 M2 writes and one done pulse.
- NPAIRS=1, M1={0,255} -> M2[0]=8'h01; neg_cnt=1; done 5 cycles after start.
- start held high -> back-to-back transfers separated by one IDLE cycle; neg_cnt cleared at each restart.
